// File: rtl/kypd_pkg.sv
// Shared definitions for the PmodKYPD keypad emulator: FSM states, the
// key-to-matrix map and the idle level of the row lines.
package kypd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
  } key_pos_t;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // Matrix position of a hex key; index 0 is line bit 3.
  function automatic key_pos_t key_pos(input logic [3:0] key);
    key_pos_t pos;
    case (key)
      4'h1:    pos = {2'd0, 2'd0};
      4'h2:    pos = {2'd1, 2'd0};
      4'h3:    pos = {2'd2, 2'd0};
      4'hA:    pos = {2'd3, 2'd0};
      4'h4:    pos = {2'd0, 2'd1};
      4'h5:    pos = {2'd1, 2'd1};
      4'h6:    pos = {2'd2, 2'd1};
      4'hB:    pos = {2'd3, 2'd1};
      4'h7:    pos = {2'd0, 2'd2};
      4'h8:    pos = {2'd1, 2'd2};
      4'h9:    pos = {2'd2, 2'd2};
      4'hC:    pos = {2'd3, 2'd2};
      4'h0:    pos = {2'd0, 2'd3};
      4'hF:    pos = {2'd1, 2'd3};
      4'hE:    pos = {2'd2, 2'd3};
      default: pos = {2'd3, 2'd3};
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/kypd_row_drive.sv
// Registered row response: pulls the held key's row low whenever the scanner
// drives that key's column low while the contact is closed.
module kypd_row_drive
  import kypd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pressed,
  input  logic [3:0] key,
  input  logic [3:0] col,
  output logic [3:0] row
);

  key_pos_t   pos;
  logic       hit;
  logic [3:0] row_reg;
  logic [3:0] row_next;

  assign pos = key_pos(key);
  // Map index 0 sits on line bit 3, so the bit select is the inverted index.
  assign hit = pressed && !col[~pos.col];

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row_next[gi] = !(hit && (pos.row == ~2'(gi)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg <= ROW_IDLE;
    end else begin
      row_reg <= row_next;
    end
  end

  assign row = row_reg;

endmodule

// File: rtl/kypd_emulator.sv
// PmodKYPD keypad emulator: sequences one key request at a time through
// optional bounce, hold and release gap, and answers the column scan.
module kypd_emulator
  import kypd_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int MS_CYCLES      = 100000,
  parameter int GAP_MS         = 20,
  parameter int BOUNCE_CYCLES  = 5000,
  parameter int BOUNCE_TOGGLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_key,
  input  logic [7:0] req_hold_ms,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       pressed,
  output logic       busy
);

  localparam int MSW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam int BCW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int BPW = (BOUNCE_TOGGLES > 0) ? $clog2(BOUNCE_TOGGLES + 1) : 1;
  localparam logic [MSW-1:0] MS_LAST   = MSW'(MS_CYCLES - 1);
  localparam logic [BCW-1:0] BC_LAST   = BCW'(BOUNCE_CYCLES - 1);
  localparam logic [BPW-1:0] BP_LAST   = BPW'(BOUNCE_TOGGLES - 1);
  localparam logic [7:0]     GAP_TALLY = 8'(GAP_MS);
  localparam bit             BOUNCE_EN = (BOUNCE_TOGGLES > 0);

  // CLK_HZ only documents the clock the timing units were sized for.
  if (CLK_HZ < MS_CYCLES) begin : g_clk_below_ms_unit
  end

  state_t         state_reg, state_next;
  logic [MSW-1:0] ms_cnt_reg, ms_cnt_next;
  logic [7:0]     ms_tally_reg, ms_tally_next;
  logic [BCW-1:0] bnc_cnt_reg, bnc_cnt_next;
  logic [BPW-1:0] bnc_ph_reg, bnc_ph_next;
  logic [3:0]     key_reg, key_next;
  logic [7:0]     hold_reg, hold_next;
  logic [7:0]     ms_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ms_cnt_reg   <= '0;
      ms_tally_reg <= '0;
      bnc_cnt_reg  <= '0;
      bnc_ph_reg   <= '0;
      key_reg      <= '0;
      hold_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      ms_cnt_reg   <= ms_cnt_next;
      ms_tally_reg <= ms_tally_next;
      bnc_cnt_reg  <= bnc_cnt_next;
      bnc_ph_reg   <= bnc_ph_next;
      key_reg      <= key_next;
      hold_reg     <= hold_next;
    end
  end

  // A hold of 0 ms behaves as 1 ms; the tally stops at target-1 so 255 never wraps.
  assign ms_target = (state_reg == GAP) ? GAP_TALLY :
                     ((hold_reg == 8'd0) ? 8'd1 : hold_reg);

  always_comb begin
    state_next    = state_reg;
    ms_cnt_next   = ms_cnt_reg;
    ms_tally_next = ms_tally_reg;
    bnc_cnt_next  = bnc_cnt_reg;
    bnc_ph_next   = bnc_ph_reg;
    key_next      = key_reg;
    hold_next     = hold_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          key_next   = req_key;
          hold_next  = req_hold_ms;
          state_next = BOUNCE_EN ? BOUNCE_IN : HOLD;
        end
      end
      BOUNCE_IN, BOUNCE_OUT: begin
        if (bnc_cnt_reg == BC_LAST) begin
          bnc_cnt_next = '0;
          if (bnc_ph_reg == BP_LAST) begin
            state_next = (state_reg == BOUNCE_IN) ? HOLD : GAP;
          end else begin
            bnc_ph_next = bnc_ph_reg + 1'b1;
          end
        end else begin
          bnc_cnt_next = bnc_cnt_reg + 1'b1;
        end
      end
      HOLD, GAP: begin
        if (ms_cnt_reg == MS_LAST) begin
          ms_cnt_next = '0;
          if (ms_tally_reg == ms_target - 8'd1) begin
            if (state_reg == GAP) begin
              state_next = IDLE;
            end else begin
              state_next = BOUNCE_EN ? BOUNCE_OUT : GAP;
            end
          end else begin
            ms_tally_next = ms_tally_reg + 8'd1;
          end
        end else begin
          ms_cnt_next = ms_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Every phase starts its timers from zero.
    if (state_next != state_reg) begin
      ms_cnt_next   = '0;
      ms_tally_next = '0;
      bnc_cnt_next  = '0;
      bnc_ph_next   = '0;
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign pressed   = (state_reg == HOLD) ||
                     ((state_reg == BOUNCE_IN) && !bnc_ph_reg[0]) ||
                     ((state_reg == BOUNCE_OUT) && bnc_ph_reg[0]);

  kypd_row_drive u_row_drive (
    .clk     (clk),
    .rst     (rst),
    .pressed (pressed),
    .key     (key_reg),
    .col     (Col),
    .row     (Row)
  );

endmodule

// File: tb/tb_kypd_emulator.sv
// Bench for kypd_emulator: two instances (no bounce / 3-toggle bounce) checked
// every cycle against a timeline model of pressed, busy, ready and Row.
`timescale 1ns/1ps
module tb_kypd_emulator;

  localparam int MS    = 10;
  localparam int GAPMS = 3;
  localparam int BCYC  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [3:0] req_key  [2];
  logic [7:0] req_hold [2];
  logic [3:0] col      [2];
  wire  [1:0] req_ready;
  wire  [1:0] pressed;
  wire  [1:0] busy;
  wire  [3:0] row      [2];

  always #5 clk = ~clk;

  kypd_emulator #(
    .CLK_HZ(100000000), .MS_CYCLES(MS), .GAP_MS(GAPMS),
    .BOUNCE_CYCLES(BCYC), .BOUNCE_TOGGLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_key(req_key[0]), .req_hold_ms(req_hold[0]), .Col(col[0]), .Row(row[0]),
    .pressed(pressed[0]), .busy(busy[0])
  );

  kypd_emulator #(
    .CLK_HZ(100000000), .MS_CYCLES(MS), .GAP_MS(GAPMS),
    .BOUNCE_CYCLES(BCYC), .BOUNCE_TOGGLES(3)
  ) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_key(req_key[1]), .req_hold_ms(req_hold[1]), .Col(col[1]), .Row(row[1]),
    .pressed(pressed[1]), .busy(busy[1])
  );

  // Physical keypad layout, [row][column], row 0 / column 0 on line bit 3.
  logic [3:0] layout [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'h0, 4'hF, 4'hE, 4'hD}};

  int         checks = 0;
  int         failures = 0;
  bit         m_active [2];
  int         m_t      [2];
  logic [3:0] m_key    [2];
  logic [7:0] m_hold   [2];
  logic [3:0] prev_col [2];
  logic       prev_pressed [2];
  int         col_mode = 0;
  int         scan_cnt = 0;
  logic [4:0] decoded;

  function automatic int bt_of(int i);
    return (i == 1) ? 3 : 0;
  endfunction

  function automatic int hold_cycles(int i);
    return ((m_hold[i] == 8'd0) ? 1 : int'(m_hold[i])) * MS;
  endfunction

  function automatic int total_cycles(int i);
    return 2 * bt_of(i) * BCYC + hold_cycles(i) + GAPMS * MS;
  endfunction

  // Contact level t cycles after acceptance: bounce-in, hold, bounce-out, gap.
  function automatic logic model_pressed(int i);
    int t, bi, h;
    if (!m_active[i]) return 1'b0;
    t  = m_t[i];
    bi = bt_of(i) * BCYC;
    h  = hold_cycles(i);
    if (t < bi) return ((t / BCYC) % 2) == 0;
    t -= bi;
    if (t < h) return 1'b1;
    t -= h;
    if (t < bi) return ((t / BCYC) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_row(logic [3:0] c, logic p, logic [3:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (p && layout[ri][ci] == k && !c[3-ci]) r[3-ri] = 1'b0;
    return r;
  endfunction

  // Scanner-side decoder: driven column plus returned row -> key code.
  function automatic logic [4:0] decode(logic [3:0] c, logic [3:0] r);
    logic [4:0] k;
    k = 5'h1E;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (!c[3-ci] && !r[3-ri]) k = {1'b0, layout[ri][ci]};
    return k;
  endfunction

  task automatic check(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, i, $time, obs, exp);
    end
  endtask

  // One clock: compare outputs with the model, drive Col, advance the model.
  task automatic step();
    logic       pe, be;
    logic [3:0] nc;
    int         r;
    bit         acc [2];
    logic [3:0] ak [2];
    logic [7:0] ah [2];
    for (int i = 0; i < 2; i++) begin
      pe = model_pressed(i);
      be = m_active[i];
      check("pressed", i, 32'(pressed[i]), 32'(pe));
      check("busy", i, 32'(busy[i]), 32'(be));
      check("req_ready", i, 32'(req_ready[i]), 32'(!be));
      check("row", i, 32'(row[i]), 32'(exp_row(prev_col[i], prev_pressed[i], m_key[i])));
      if (i == 0 && row[0] != 4'hF) decoded = decode(prev_col[0], row[0]);
      if (i == 0 && col_mode == 1) begin
        nc = 4'b1111 ^ (4'b1000 >> ((scan_cnt / 2) % 4));
      end else begin
        r = $urandom_range(0, 5);
        if (r < 4)       nc = 4'b1111 ^ (4'b1000 >> r);
        else if (r == 4) nc = 4'hF;
        else             nc = 4'($urandom);
      end
      col[i]          = nc;
      prev_col[i]     = nc;
      prev_pressed[i] = rst ? 1'b0 : pe;
      acc[i] = !rst && req_valid[i] && !be;
      ak[i]  = req_key[i];
      ah[i]  = req_hold[i];
    end
    scan_cnt++;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] = 1'b0;
      end else if (acc[i]) begin
        m_active[i] = 1'b1;
        m_t[i]      = 0;
        m_key[i]    = ak[i];
        m_hold[i]   = ah[i];
      end else if (m_active[i]) begin
        m_t[i]++;
        if (m_t[i] >= total_cycles(i)) m_active[i] = 1'b0;
      end
    end
  endtask

  task automatic request(int i, logic [3:0] k, logic [7:0] h, output int waited);
    bit will;
    req_valid[i] = 1'b1;
    req_key[i]   = k;
    req_hold[i]  = h;
    waited = 0;
    will   = 1'b0;
    while (!will && waited <= 2000) begin
      will = !m_active[i] && !rst;
      step();
      waited++;
    end
    req_valid[i] = 1'b0;
    check("accept_bound", i, 32'(waited <= 2000), 32'd1);
  endtask

  task automatic run_until_idle(int i);
    int n;
    n = 0;
    while (m_active[i] && n < 5000) begin
      step();
      n++;
    end
    check("idle_reached", i, 32'(busy[i]), 32'd0);
  endtask

  initial begin
    int w, hi, rises;
    logic pp;
    rst       = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_key[i]      = 4'h0;
      req_hold[i]     = 8'd0;
      col[i]          = 4'hF;
      prev_col[i]     = 4'hF;
      prev_pressed[i] = 1'b0;
      m_active[i]     = 1'b0;
      m_t[i]          = 0;
      m_key[i]        = 4'h0;
      m_hold[i]       = 8'd1;
    end
    decoded = 5'h1F;

    // Reset for two cycles, then idle with the scanner cycling columns.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    col_mode = 1;
    repeat (8) step();
    col_mode = 0;

    // Key 5, hold 2 ms, random columns; a request in the last gap cycle waits.
    request(0, 4'h5, 8'd2, w);
    hi = 0;
    while (m_active[0] && m_t[0] != total_cycles(0) - 1) begin
      hi += int'(pressed[0]);
      step();
    end
    check("hold_cycles", 0, 32'(hi), 32'(2 * MS));
    request(0, 4'h3, 8'd1, w);
    check("gap_final_cycle_wait", 0, 32'(w), 32'd2);
    run_until_idle(0);

    // All 16 keys through the scanning decoder at 30 ms.
    col_mode = 1;
    for (int k = 0; k < 16; k++) begin
      decoded = 5'h1F;
      request(0, 4'(k), 8'd30, w);
      run_until_idle(0);
      check("decode", 0, 32'(decoded), 32'(k));
    end
    col_mode = 0;

    // Bounce instance, key A: 1,0,1 in, 0,1,0 out.
    request(1, 4'hA, 8'd1, w);
    hi = 0;
    rises = 0;
    pp = 1'b0;
    while (m_active[1]) begin
      hi += int'(pressed[1]);
      if (pressed[1] && !pp) rises++;
      pp = pressed[1];
      step();
    end
    check("bounce_high_cycles", 1, 32'(hi), 32'(2 * BCYC + MS + BCYC));
    check("bounce_rises", 1, 32'(rises), 32'd3);

    // req_valid held with changing key/hold on both instances.
    req_valid = 2'b11;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        req_key[i]  = 4'($urandom);
        req_hold[i] = 8'($urandom_range(0, 3));
      end
      step();
    end
    req_valid = 2'b00;
    run_until_idle(0);
    run_until_idle(1);

    // Reset in the middle of holding key 9, then key 1 right away.
    request(0, 4'h9, 8'd5, w);
    while (m_active[0] && m_t[0] < 25) step();
    check("mid_hold_pressed", 0, 32'(pressed[0]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    request(0, 4'h1, 8'd2, w);
    check("accept_after_reset", 0, 32'(w), 32'd1);
    run_until_idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kypd_emulator.md
Name: kypd_emulator

Overview:
- Behavioural responder for the 4x4 PmodKYPD matrix. It plays the keypad side of the scan interface.
- It watches the column lines driven by the scanning decoder and pulls the matching row line low while an emulated key is held.
- Key presses arrive through a valid/ready request port, one at a time. Each has a programmable hold time, optional contact bounce and an enforced release gap.
- Used in simulation benches and on-board self-test in place of the physical keypad on port JA.

Parameters:
- CLK_HZ, 100000000, clock frequency in Hz; documentation only.
- MS_CYCLES, 100000, clock cycles per hold/gap time unit (1 ms at 100 MHz).
- GAP_MS, 20, release time in ms enforced after each key before the next request is accepted.
- BOUNCE_CYCLES, 5000, cycles per bounce toggle phase.
- BOUNCE_TOGGLES, 0, number of contact toggles at press and at release; 0 disables bounce.

Ports:
- clk, in, 1, system clock (100 MHz).
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, key request present.
- req_ready, out, 1, emulator can accept a request.
- req_key, in, 4, hex key code 0x0-0xF.
- req_hold_ms, in, 8, hold duration in ms; 0 is treated as 1.
- Col, in, 4, column lines from the scanner, active low.
- Row, out, 4, row lines to the scanner, active low, idle 4'b1111.
- pressed, out, 1, emulated contact currently closed.
- busy, out, 1, a request is in progress (any state other than IDLE).

Behaviour:
- Reset (synchronous, active-high rst on the clk edge): state IDLE, Row=4'b1111, pressed=0, busy=0, req_ready=1, all counters cleared.
- Reset mid-operation aborts the key immediately. No gap is applied.
- Handshake:
  - A request is accepted on a cycle where req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - req_key and req_hold_ms are latched on acceptance; later changes on those inputs are ignored.
- Key map: key -> (column index, row index), index 0 = bit 3 (value 0111):
  - 1=(0,0), 2=(1,0), 3=(2,0), A=(3,0)
  - 4=(0,1), 5=(1,1), 6=(2,1), B=(3,1)
  - 7=(0,2), 8=(1,2), 9=(2,2), C=(3,2)
  - 0=(0,3), F=(1,3), E=(2,3), D=(3,3)
- Row generation (registered, 1-cycle latency from Col):
  - When pressed=1 and Col bit for the key's column is 0: Row has the key's row bit = 0 and all other bits = 1.
  - Otherwise Row=4'b1111.
  - Col need not be one-hot: any low bit matching the key's column drives the row. Col=1111 always gives Row=1111.
- State machine:
  - IDLE -> BOUNCE_IN on accept, or -> HOLD if BOUNCE_TOGGLES=0.
  - BOUNCE_IN: pressed toggles every BOUNCE_CYCLES, starting at 1, for BOUNCE_TOGGLES phases; pressed then settles at 1 -> HOLD.
  - HOLD: pressed=1 for max(req_hold_ms,1)*MS_CYCLES cycles -> BOUNCE_OUT, or -> GAP if bounce is disabled.
  - BOUNCE_OUT: mirror of BOUNCE_IN, starting at 0 and ending with pressed=0 -> GAP.
  - GAP: pressed=0 for GAP_MS*MS_CYCLES cycles -> IDLE.
- Counter widths:
  - ms counter: clog2(MS_CYCLES).
  - ms tally: 8 bits, must not wrap at hold=255.
  - bounce counters: clog2(BOUNCE_CYCLES) and clog2(BOUNCE_TOGGLES+1).
- Durations are exact: pressed rises the cycle after acceptance, with no extra idle cycle.
- A simultaneous req_valid in the final GAP cycle is not accepted. It is accepted the next cycle in IDLE.

Decomposition:
- Shared package kypd_pkg holds:
  - the key-to-(col,row) map function;
  - state encoding constants (IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP);
  - the idle row constant 4'b1111.
- One sub-module, kypd_row_drive: registered Col/pressed/key -> Row mapping. The sequencing FSM and timers stay in the top level.

Test Plan:
1. Reset with rst=1 for 2 cycles -> Row=1111, pressed=0, req_ready=1; Col cycling 0111/1011/1101/1110 gives Row=1111 throughout.
2. Request key 5, hold 2, MS_CYCLES=10, no bounce -> pressed high for exactly 20 cycles; Row=1011 only one cycle after Col=1011, else 1111; GAP then lasts GAP_MS*10 cycles.
3. Run all 16 keys through the full PmodKYPD decoder at hold 30 ms -> decoder output equals req_key for every key (e.g. D -> 4'hD, 0 -> 4'h0).
4. BOUNCE_TOGGLES=3, BOUNCE_CYCLES=4, key A -> pressed pattern 1,0,1 in 4-cycle phases, then steady 1; mirrored pattern at release.
5. Keep req_valid high with key changes while busy -> req_ready=0 and no new acceptance until IDLE; the latched key is unchanged mid-hold.
6. Assert rst mid-HOLD of key 9 -> next cycle Row=1111, pressed=0, req_ready=1; a new request for key 1 is accepted immediately.
